// File: rtl/cube_net_renderer.sv
// rtl/cube_net_renderer.sv - Rubik cube net renderer driving a 160x120 9-bit pixel write port.
// Full redraw clears the screen then draws all six faces; partial redraw draws only the masked faces.
module cube_net_renderer #(
  parameter int          N         = 3,
  parameter int          CELL      = 8,
  parameter int          BORDER    = 1,
  parameter int          X0        = 0,
  parameter int          Y0        = 0,
  parameter logic [8:0]  HL_COLOUR = 9'b111100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_redraw,
  input  logic [5:0]            i_face_redraw,
  input  logic [6*N*N*3-1:0]    i_stickers,
  input  logic                  i_hl_en,
  input  logic [2:0]            i_hl_face,
  input  logic [3:0]            i_hl_idx,
  output logic [7:0]            o_x,
  output logic [6:0]            o_y,
  output logic [8:0]            o_colour,
  output logic                  o_plot,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int SBW = $clog2(6*N*N*3);
  localparam int RW  = $clog2(N);
  localparam int CW  = $clog2(CELL);
  localparam logic [RW-1:0] RC_LAST = RW'(N-1);
  localparam logic [CW-1:0] LX_LAST = CW'(CELL-1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic                r_pend_full;
  logic [5:0]          r_pend_mask, r_mask;
  logic [6*N*N*3-1:0]  r_snap;
  logic                r_hl_en;
  logic [2:0]          r_hl_face;
  logic [3:0]          r_hl_idx;
  logic [7:0]          r_cx;
  logic [6:0]          r_cy;
  logic [2:0]          r_slot;
  logic [RW-1:0]       r_row, r_col;
  logic [CW-1:0]       r_ly, r_lx;

  logic [2:0]          w_face;
  logic [1:0]          w_sc, w_sr;
  logic                w_sel, w_leave, w_clear_last, w_face_last, w_draw_last;
  logic                w_border, w_hl;
  logic [SBW-1:0]      w_bit;
  logic [2:0]          w_code;
  logic [8:0]          w_fill;
  int                  w_px, w_py;
  logic [7:0]          w_x;
  logic [6:0]          w_y;
  logic [8:0]          w_colour;
  logic                w_plot, w_done;

  // Draw order U, L, F, R, B, D mapped to bus face id and net slot position.
  always_comb begin
    w_face = 3'd5; w_sc = 2'd1; w_sr = 2'd2;
    case (r_slot)
      3'd0:    begin w_face = 3'd4; w_sc = 2'd1; w_sr = 2'd0; end
      3'd1:    begin w_face = 3'd2; w_sc = 2'd0; w_sr = 2'd1; end
      3'd2:    begin w_face = 3'd0; w_sc = 2'd1; w_sr = 2'd1; end
      3'd3:    begin w_face = 3'd3; w_sc = 2'd2; w_sr = 2'd1; end
      3'd4:    begin w_face = 3'd1; w_sc = 2'd3; w_sr = 2'd1; end
      default: begin w_face = 3'd5; w_sc = 2'd1; w_sr = 2'd2; end
    endcase
  end

  assign w_sel        = r_mask[w_face];
  assign w_leave      = (r_state == S_IDLE) && (w_state_nx != S_IDLE);
  assign w_clear_last = (r_cx == 8'd159) && (r_cy == 7'd119);
  assign w_face_last  = (r_lx == LX_LAST) && (r_ly == LX_LAST) && (r_col == RC_LAST) && (r_row == RC_LAST);
  assign w_draw_last  = (r_slot == 3'd5) && (!w_sel || w_face_last);

  assign w_bit    = SBW'((int'(w_face) * N * N + int'(r_row) * N + int'(r_col)) * 3);
  assign w_code   = r_snap[w_bit +: 3];
  assign w_border = (int'(r_lx) < BORDER) || (int'(r_lx) >= CELL - BORDER) ||
                    (int'(r_ly) < BORDER) || (int'(r_ly) >= CELL - BORDER);
  // Out-of-range hl_idx/hl_face can never equal a real sticker, so no explicit range check is needed.
  assign w_hl     = r_hl_en && (r_hl_face == w_face) &&
                    (int'(r_hl_idx) == int'(r_row) * N + int'(r_col));
  assign w_px     = X0 + int'(w_sc) * N * CELL + int'(r_col) * CELL + int'(r_lx);
  assign w_py     = Y0 + int'(w_sr) * N * CELL + int'(r_row) * CELL + int'(r_ly);

  always_comb begin
    w_fill = 9'h000;
    case (w_code)
      3'd0:    w_fill = 9'h1FF;
      3'd1:    w_fill = 9'h1F8;
      3'd2:    w_fill = 9'h007;
      3'd3:    w_fill = 9'h038;
      3'd4:    w_fill = 9'h1C0;
      3'd5:    w_fill = 9'h1C7;
      default: w_fill = 9'h000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_CLEAR;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend_full)      w_state_nx = S_CLEAR;
        else if (|r_pend_mask) w_state_nx = S_DRAW;
      end
      S_CLEAR: if (w_clear_last) w_state_nx = S_DRAW;
      S_DRAW:  if (w_draw_last)  w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (r_state != S_IDLE);
    w_plot   = 1'b0;
    w_done   = 1'b0;
    w_x      = 8'd0;
    w_y      = 7'd0;
    w_colour = 9'h000;
    case (r_state)
      S_CLEAR: begin
        w_plot = 1'b1;
        w_x    = r_cx;
        w_y    = r_cy;
      end
      S_DRAW: begin
        w_plot   = w_sel;
        w_x      = 8'(w_px);
        w_y      = 7'(w_py);
        w_colour = w_border ? (w_hl ? HL_COLOUR : 9'h000) : w_fill;
      end
      S_DONE:  w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_x <= 8'd0; o_y <= 7'd0; o_colour <= 9'h000; o_plot <= 1'b0; o_done <= 1'b0;
    end else begin
      o_x <= w_x; o_y <= w_y; o_colour <= w_colour; o_plot <= w_plot; o_done <= w_done;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_full <= 1'b0;
      r_pend_mask <= 6'h00;
      r_mask      <= 6'h3F;
      r_snap      <= i_stickers;
      r_hl_en     <= i_hl_en;
      r_hl_face   <= i_hl_face;
      r_hl_idx    <= i_hl_idx;
      r_cx <= 8'd0; r_cy <= 7'd0;
      r_slot <= 3'd0; r_row <= '0; r_col <= '0; r_ly <= '0; r_lx <= '0;
    end else begin
      // Leaving IDLE consumes every pending flag; a full redraw absorbs any partial mask.
      r_pend_full <= (r_pend_full & ~w_leave) | i_redraw;
      r_pend_mask <= (r_pend_mask & {6{~w_leave}}) | i_face_redraw;
      if (w_leave) begin
        r_mask    <= r_pend_full ? 6'h3F : r_pend_mask;
        r_snap    <= i_stickers;
        r_hl_en   <= i_hl_en;
        r_hl_face <= i_hl_face;
        r_hl_idx  <= i_hl_idx;
      end
      if (r_state == S_CLEAR) begin
        if (r_cx == 8'd159) begin
          r_cx <= 8'd0;
          r_cy <= r_cy + 7'd1;
        end else begin
          r_cx <= r_cx + 8'd1;
        end
      end else begin
        r_cx <= 8'd0; r_cy <= 7'd0;
      end
      if (r_state == S_DRAW) begin
        if (!w_sel) begin
          r_slot <= r_slot + 3'd1;
          r_row <= '0; r_col <= '0; r_ly <= '0; r_lx <= '0;
        end else if (r_lx != LX_LAST) begin
          r_lx <= r_lx + CW'(1);
        end else begin
          r_lx <= '0;
          if (r_ly != LX_LAST) begin
            r_ly <= r_ly + CW'(1);
          end else begin
            r_ly <= '0;
            if (r_col != RC_LAST) begin
              r_col <= r_col + RW'(1);
            end else begin
              r_col <= '0;
              if (r_row != RC_LAST) begin
                r_row <= r_row + RW'(1);
              end else begin
                r_row  <= '0;
                r_slot <= r_slot + 3'd1;
              end
            end
          end
        end
      end else begin
        r_slot <= 3'd0; r_row <= '0; r_col <= '0; r_ly <= '0; r_lx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cube_net_renderer.sv
// tb/tb_cube_net_renderer.sv - scoreboard bench for cube_net_renderer (defaults plus an N=4 reset-abort instance).
module tb_cube_net_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, redraw, hl_en;
  logic [5:0]   face_redraw;
  logic [161:0] stk;
  logic [2:0]   hl_face;
  logic [3:0]   hl_idx;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [8:0]   colour;
  logic         plot, busy, done;

  logic         rst4;
  logic [287:0] stk4 = '0;
  logic [7:0]   x4;
  logic [6:0]   y4;
  logic [8:0]   c4;
  logic         plot4, busy4, done4;

  cube_net_renderer dut (
    .i_clk(clk), .i_reset(rst), .i_redraw(redraw), .i_face_redraw(face_redraw),
    .i_stickers(stk), .i_hl_en(hl_en), .i_hl_face(hl_face), .i_hl_idx(hl_idx),
    .o_x(x), .o_y(y), .o_colour(colour), .o_plot(plot), .o_busy(busy), .o_done(done)
  );

  cube_net_renderer #(.N(4), .CELL(4), .BORDER(1)) dut4 (
    .i_clk(clk), .i_reset(rst4), .i_redraw(1'b0), .i_face_redraw(6'h00),
    .i_stickers(stk4), .i_hl_en(1'b0), .i_hl_face(3'd0), .i_hl_idx(4'd0),
    .o_x(x4), .o_y(y4), .o_colour(c4), .o_plot(plot4), .o_busy(busy4), .o_done(done4)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int plots; int idle; int fx; int fy;
    int xl; int xh; int yl; int yh; int lastplot;
  } rec_t;

  rec_t sb_q[$];
  int   n_push = 0;
  int   pr_rn[64], pr_x[64], pr_y[64], pr_exp[64], pr_seen[64];
  int   n_pr = 0;

  task automatic expect_render(int plots, int idle, int fx, int fy, int xl, int xh, int yl, int yh, int lastplot);
    rec_t r;
    r.plots = plots; r.idle = idle; r.fx = fx; r.fy = fy;
    r.xl = xl; r.xh = xh; r.yl = yl; r.yh = yh; r.lastplot = lastplot;
    sb_q.push_back(r);
    n_push++;
  endtask

  task automatic add_probe(int px, int py, int c);
    pr_rn[n_pr] = n_push - 1; pr_x[n_pr] = px; pr_y[n_pr] = py;
    pr_exp[n_pr] = c; pr_seen[n_pr] = -1;
    n_pr++;
  endtask

  // Monitor: accumulates each render's plots and pops its expectation on the done pulse.
  bit   mon_en = 1'b0;
  int   m_rn = 0, m_plots = 0, m_idle = 0, m_fx = -1, m_fy = -1;
  int   m_xl = 999, m_xh = -1, m_yl = 999, m_yh = -1;
  bit   m_prev_plot = 1'b0, m_prev_done = 1'b0;
  rec_t m_r;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_prev_done) check("done_width", int'(done), 0);
      if (plot) begin
        if (m_plots == 0) begin m_fx = int'(x); m_fy = int'(y); end
        m_plots++;
        if (int'(x) < m_xl) m_xl = int'(x);
        if (int'(x) > m_xh) m_xh = int'(x);
        if (int'(y) < m_yl) m_yl = int'(y);
        if (int'(y) > m_yh) m_yh = int'(y);
        for (int i = 0; i < n_pr; i++)
          if (pr_rn[i] == m_rn && pr_x[i] == int'(x) && pr_y[i] == int'(y)) pr_seen[i] = int'(colour);
      end else if (busy) begin
        m_idle++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: render %0d had no expected entry", m_rn);
        end else begin
          m_r = sb_q.pop_front();
          check($sformatf("r%0d_plots", m_rn), m_plots, m_r.plots);
          check($sformatf("r%0d_idle_cycles", m_rn), m_idle, m_r.idle);
          check($sformatf("r%0d_first_x", m_rn), m_fx, m_r.fx);
          check($sformatf("r%0d_first_y", m_rn), m_fy, m_r.fy);
          check($sformatf("r%0d_xmin", m_rn), m_xl, m_r.xl);
          check($sformatf("r%0d_xmax", m_rn), m_xh, m_r.xh);
          check($sformatf("r%0d_ymin", m_rn), m_yl, m_r.yl);
          check($sformatf("r%0d_ymax", m_rn), m_yh, m_r.yh);
          check($sformatf("r%0d_plot_before_done", m_rn), int'(m_prev_plot), m_r.lastplot);
        end
        check($sformatf("r%0d_busy_at_done", m_rn), int'(busy), 0);
        for (int i = 0; i < n_pr; i++)
          if (pr_rn[i] == m_rn)
            check($sformatf("r%0d_pixel_%0d_%0d", m_rn, pr_x[i], pr_y[i]), pr_seen[i], pr_exp[i]);
        m_rn++;
        m_plots = 0; m_idle = 0; m_fx = -1; m_fy = -1;
        m_xl = 999; m_xh = -1; m_yl = 999; m_yh = -1;
      end
      m_prev_plot = plot;
      m_prev_done = done;
    end
  end

  task automatic wait_done(int budget);
    int c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL render_timeout: %0d renders outstanding after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_req(bit full, logic [5:0] m);
    redraw = full;
    face_redraw = m;
    @(negedge clk);
    redraw = 1'b0;
    face_redraw = 6'h00;
  endtask

  task automatic set_face(int k, int code);
    for (int i = 0; i < 9; i++) stk[(k*9+i)*3 +: 3] = 3'(code);
  endtask

  bit d4_fin = 1'b0;

  // N=4, CELL=4: abort at draw plot 100, then expect a clean restart from (0,0).
  initial begin : p_dut4
    int p, dpre, c, fx, fy;
    bit seen_done;
    rst4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    p = 0; dpre = 0; c = 0;
    while (p < 19300 && c < 30000) begin
      @(negedge clk);
      c++;
      if (done4) dpre++;
      if (plot4) p++;
    end
    check("n4_plots_before_abort", p, 19300);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("n4_plot_during_reset", int'(plot4), 0);
    check("n4_done_during_reset", int'(done4), 0);
    check("n4_busy_after_reset", int'(busy4), 1);
    p = 0; c = 0; fx = -1; fy = -1; seen_done = 1'b0;
    while (!seen_done && c < 30000) begin
      @(negedge clk);
      c++;
      if (plot4) begin
        if (p == 0) begin fx = int'(x4); fy = int'(y4); end
        p++;
      end
      if (done4) begin
        seen_done = 1'b1;
        check("n4_busy_at_done", int'(busy4), 0);
      end
    end
    check("n4_no_done_before_abort", dpre, 0);
    check("n4_restart_x", fx, 0);
    check("n4_restart_y", fy, 0);
    check("n4_full_plots", p, 20736);
    check("n4_done_seen", int'(seen_done), 1);
    d4_fin = 1'b1;
  end

  initial begin : p_main
    int c;
    rst = 1'b1; redraw = 1'b0; face_redraw = 6'h00; stk = '0;
    hl_en = 1'b0; hl_face = 3'd0; hl_idx = 4'd0;

    // Power-up full render with all stickers white.
    expect_render(22656, 1, 0, 0, 0, 159, 0, 119, 1);
    add_probe(33, 9, 9'h1FF);
    add_probe(24, 0, 9'h000);
    add_probe(100, 100, 9'h000);
    add_probe(12, 36, 9'h1FF);
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check("reset_x", int'(x), 0);
    check("reset_y", int'(y), 0);
    check("reset_colour", int'(colour), 0);
    check("reset_plot", int'(plot), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 1);
    rst = 1'b0;
    wait_done(30000);

    // Partial: face L only, stickers cycle through every colour code.
    for (int i = 0; i < 9; i++) stk[(2*9+i)*3 +: 3] = 3'(i % 8);
    expect_render(576, 6, 0, 24, 0, 23, 24, 47, 0);
    add_probe(12, 28, 9'h1F8);
    add_probe(20, 28, 9'h007);
    add_probe(4, 36, 9'h038);
    add_probe(12, 36, 9'h1C0);
    add_probe(20, 36, 9'h1C7);
    add_probe(12, 44, 9'h000);
    add_probe(20, 44, 9'h1FF);
    add_probe(8, 28, 9'h000);
    pulse_req(1'b0, 6'b000100);
    wait_done(2000);

    // Requests during a full render collapse into exactly one further full render.
    for (int r = 0; r < 2; r++) begin
      expect_render(22656, 1, 0, 0, 0, 159, 0, 119, 1);
      add_probe(33, 9, 9'h1FF);
      add_probe(12, 36, 9'h1C0);
      add_probe(100, 100, 9'h000);
      add_probe(24, 0, 9'h000);
    end
    pulse_req(1'b1, 6'h00);
    repeat (1000) @(negedge clk);
    pulse_req(1'b0, 6'b000001);
    repeat (10) @(negedge clk);
    pulse_req(1'b1, 6'h00);
    wait_done(50000);
    repeat (200) @(negedge clk);

    // Highlight on F centre sticker.
    set_face(0, 2);
    hl_en = 1'b1; hl_face = 3'd0; hl_idx = 4'd4;
    expect_render(576, 6, 24, 24, 24, 47, 24, 47, 0);
    add_probe(32, 32, 9'h1E0);
    add_probe(39, 32, 9'h1E0);
    add_probe(35, 32, 9'h1E0);
    add_probe(36, 39, 9'h1E0);
    add_probe(35, 35, 9'h007);
    add_probe(31, 32, 9'h000);
    add_probe(24, 24, 9'h000);
    pulse_req(1'b0, 6'b000001);
    wait_done(2000);

    // Out-of-range index disables highlight.
    hl_idx = 4'd9;
    expect_render(576, 6, 24, 24, 24, 47, 24, 47, 0);
    add_probe(32, 32, 9'h000);
    add_probe(35, 32, 9'h000);
    add_probe(35, 35, 9'h007);
    pulse_req(1'b0, 6'b000001);
    wait_done(2000);

    // Sticker change mid-render must not affect the snapshot.
    hl_en = 1'b0;
    set_face(0, 4);
    expect_render(576, 6, 24, 24, 24, 47, 24, 47, 0);
    add_probe(35, 35, 9'h1C0);
    add_probe(44, 44, 9'h1C0);
    pulse_req(1'b0, 6'b000001);
    repeat (20) @(negedge clk);
    set_face(0, 1);
    wait_done(2000);

    c = 0;
    while (!d4_fin && c < 60000) begin
      @(negedge clk);
      c++;
    end
    if (!d4_fin) begin
      n_vec++; n_err++;
      $display("FAIL n4_timeout: second instance did not complete within %0d cycles", c);
    end
    check("renders_completed", m_rn, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
